clk_gate_ctrl: RTL and testbench

//   Idle-detect controller that generates the enable for the downstream clk_gater.

---
 rtl/clk_gate_pkg.sv | 19 +
 rtl/clk_gate_ctrl_if.sv | 37 +++
 rtl/clk_gate_timer.sv | 28 ++
 rtl/clk_gate_ctrl.sv | 128 ++++++++++++
 tb/tb_clk_gate_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and constants for the clock-gate enable controller.
// Optional gate-entry statistics are enabled with CLK_GATE_STATS_EN.
package clk_gate_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      IDLE_WAIT = 2'd1,
      GATED     = 2'd2,
      WAKE      = 2'd3
   } state_t;

   localparam int STAT_W = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
      return (value == {STAT_W{1'b1}}) ? value : value + STAT_W'(1);
   endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Activity / wake handshake bundle between a requester and the gate controller.
// The gate_cnt member exists only when CLK_GATE_STATS_EN is defined.
interface clk_gate_ctrl_if import clk_gate_pkg::*; ();

   logic busy;
   logic wake_req;
   logic force_on;
   logic en;
   logic wake_ack;
   logic gated;
`ifdef CLK_GATE_STATS_EN
   logic [STAT_W-1:0] gate_cnt;
`endif

`ifdef CLK_GATE_STATS_EN
   modport master (
      output busy, wake_req, force_on,
      input  en, wake_ack, gated, gate_cnt
   );

   modport slave (
      input  busy, wake_req, force_on,
      output en, wake_ack, gated, gate_cnt
   );
`else
   modport master (
      output busy, wake_req, force_on,
      input  en, wake_ack, gated
   );

   modport slave (
      input  busy, wake_req, force_on,
      output en, wake_ack, gated
   );
`endif

endinterface

// File: rtl/clk_gate_timer.sv
// Shared quiet/settle timer: synchronous clear, increment, and terminal compare
// against a caller-supplied terminal value.
module clk_gate_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] term,
   output logic             at_term
);

   logic [CNT_W-1:0] cnt_q;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (inc) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign at_term = (cnt_q == term);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Idle-detect controller producing the registered enable for clk_gater, with a
// level wake_req/wake_ack handshake. CLK_GATE_STATS_EN adds a gate-entry counter.
module clk_gate_ctrl import clk_gate_pkg::*; #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W       = 8
) (
   input  logic            clk,
   input  logic            rst,
   clk_gate_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] IDLE_TERM = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_TERM = CNT_W'(WAKE_CYCLES - 1);

   state_t           state_q;
   state_t           state_d;
   logic             quiet;
   logic             timer_clr;
   logic             timer_inc;
   logic             timer_at_term;
   logic [CNT_W-1:0] timer_term;
   logic             en_q;
   logic             en_d;
   logic             wake_ack_q;
   logic             wake_ack_d;
   logic             gated_q;
   logic             gated_d;

   assign quiet      = !bus.busy && !bus.wake_req && !bus.force_on;
   assign timer_term = (state_q == WAKE) ? WAKE_TERM : IDLE_TERM;
   assign timer_clr  = !timer_inc;

   clk_gate_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (timer_clr),
      .inc     (timer_inc),
      .term    (timer_term),
      .at_term (timer_at_term)
   );

   // State register and registered outputs; reset wins over any transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         en_q       <= 1'b1;
         wake_ack_q <= 1'b1;
         gated_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         wake_ack_q <= wake_ack_d;
         gated_q    <= gated_d;
      end
   end

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      timer_inc = 1'b0;
      unique case (state_q)
         RUN: begin
            if (quiet) state_d = IDLE_WAIT;
         end
         IDLE_WAIT: begin
            // Activity is tested first so it beats a coincident timeout.
            if (!quiet) begin
               state_d = RUN;
            end else if (timer_at_term) begin
               state_d = GATED;
            end else begin
               timer_inc = 1'b1;
            end
         end
         GATED: begin
            if (!quiet) state_d = WAKE;
         end
         WAKE: begin
            // Settling always completes; inputs cannot send us back to GATED.
            if (timer_at_term) begin
               state_d = RUN;
            end else begin
               timer_inc = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same edge.
   always_comb begin
      en_d       = 1'b1;
      wake_ack_d = 1'b0;
      gated_d    = 1'b0;
      unique case (state_d)
         RUN, IDLE_WAIT: wake_ack_d = 1'b1;
         GATED: begin
            en_d    = 1'b0;
            gated_d = 1'b1;
         end
         WAKE:    wake_ack_d = 1'b0;
         default: wake_ack_d = 1'b0;
      endcase
   end

   assign bus.en       = en_q;
   assign bus.wake_ack = wake_ack_q;
   assign bus.gated    = gated_q;

`ifdef CLK_GATE_STATS_EN
   logic [STAT_W-1:0] gate_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         gate_cnt_q <= '0;
      end else if ((state_d == GATED) && (state_q != GATED)) begin
         gate_cnt_q <= sat_inc(gate_cnt_q);
      end
   end

   assign bus.gate_cnt = gate_cnt_q;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2.
// Stats checks are compiled in when CLK_GATE_STATS_EN is defined.
module tb_clk_gate_ctrl;

   localparam logic [2:0] O_RUN  = 3'b110; // {en, wake_ack, gated}
   localparam logic [2:0] O_GATE = 3'b001;
   localparam logic [2:0] O_WAKE = 3'b100;

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   clk_gate_ctrl_if bus_if ();

   clk_gate_ctrl #(
      .IDLE_CYCLES (4),
      .WAKE_CYCLES (2),
      .CNT_W       (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic busy, input logic wake_req, input logic force_on);
      bus_if.busy     = busy;
      bus_if.wake_req = wake_req;
      bus_if.force_on = force_on;
   endtask

   // One rising edge, then settle 1 time unit before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] outs();
      return {bus_if.en, bus_if.wake_ack, bus_if.gated};
   endfunction

   // Quiet for n edges, checking RUN-like outputs on each.
   task automatic quiet_run(input int n, input string tag);
      drive(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
         step();
         check(tag, outs(), O_RUN);
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst      = 1'b1;
      drive(1'b1, 1'b1, 1'b0);
      #1;

      // 1. Reset
      step();
      step();
      check("reset_outs", outs(), O_RUN);
      rst = 1'b0;
      step();
      check("run_busy", outs(), O_RUN);

      // 2. Idle entry: 5 quiet samples, gated after the 5th
      quiet_run(4, "idle_not_early");
      step();
      check("idle_gated", outs(), O_GATE);
      step();
      check("gated_hold", outs(), O_GATE);

      // 4. Wake: en at g, ack at g+2
      drive(1'b0, 1'b1, 1'b0);
      step();
      check("wake_en", outs(), O_WAKE);
      step();
      check("wake_settle", outs(), O_WAKE);
      step();
      check("wake_ack", outs(), O_RUN);
      step();
      check("wake_req_held", outs(), O_RUN);
      quiet_run(4, "regate_not_early");
      step();
      check("regate", outs(), O_GATE);

      // 3. Aborted idle: busy at quiet sample 3
      drive(1'b0, 1'b1, 1'b0);
      step();
      step();
      step();
      check("wake2_ack", outs(), O_RUN);
      quiet_run(2, "abort_pre");
      drive(1'b1, 1'b0, 1'b0);
      step();
      check("abort_run", outs(), O_RUN);
      quiet_run(4, "abort_not_early");
      step();
      check("abort_regate", outs(), O_GATE);

      // Activity on the timeout edge beats the timeout
      drive(1'b1, 1'b0, 1'b0);
      step();
      check("busy_wakes", outs(), O_WAKE);
      step();
      step();
      check("busy_wake_done", outs(), O_RUN);
      quiet_run(4, "tie_pre");
      drive(1'b1, 1'b0, 1'b0);
      step();
      check("tie_activity_wins", outs(), O_RUN);

      // force_on held keeps RUN; it also wakes from GATED
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step();
      check("force_on_never_gates", outs(), O_RUN);
      quiet_run(4, "force_pre");
      step();
      check("force_pre_gated", outs(), O_GATE);
      drive(1'b0, 1'b0, 1'b1);
      step();
      check("force_wakes", outs(), O_WAKE);
      // Inputs ignored in WAKE: dropping force_on does not abort
      drive(1'b0, 1'b0, 1'b0);
      step();
      check("wake_no_abort", outs(), O_WAKE);
      step();
      check("wake_no_abort_ack", outs(), O_RUN);

      // 5. Reset mid-GATED and mid-WAKE
      quiet_run(4, "rst_pre");
      step();
      check("rst_pre_gated", outs(), O_GATE);
      rst = 1'b1;
      step();
      check("rst_in_gated", outs(), O_RUN);
      rst = 1'b0;
      quiet_run(4, "rst2_pre");
      step();
      check("rst2_pre_gated", outs(), O_GATE);
      drive(1'b0, 1'b1, 1'b0);
      step();
      check("rst2_wake", outs(), O_WAKE);
      rst = 1'b1;
      step();
      check("rst_in_wake", outs(), O_RUN);
      rst = 1'b0;
      step();
      check("post_rst_run", outs(), O_RUN);

`ifdef CLK_GATE_STATS_EN
      // 6. Stats: counter cleared by reset, 3 gate/wake cycles
      rst = 1'b1;
      step();
      check("stats_reset", 32'(bus_if.gate_cnt), 32'h0);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         quiet_run(4, "stats_pre");
         step();
         drive(1'b0, 1'b1, 1'b0);
         step();
         step();
         step();
      end
      check("stats_three", 32'(bus_if.gate_cnt), 32'h3);
      force dut.gate_cnt_q = 16'hFFFF;
      step();
      release dut.gate_cnt_q;
      quiet_run(4, "stats_sat_pre");
      step();
      check("stats_sat_gated", outs(), O_GATE);
      step();
      check("stats_sat", 32'(bus_if.gate_cnt), 32'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
